regr_write_arbiter: RTL and testbench
=====================================

Name: regr_write_arbiter

Overview:
- Shares the single write port of the 16-bit R register among NUM_CORES requesters (core ALUs, AC-to-R transfers, load paths).
- Round-robin, one write per cycle.
- Drives the R register's write enable and data input from registered outputs.
- Returns a one-cycle ack to the granted requester.

Parameters:
NUM_CORES, 4, number of requesters (2..8)
DATA_WIDTH, 16, width of R register data
ID_WIDTH, 2, width of grant index; must satisfy 2^ID_WIDTH >= NUM_CORES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NUM_CORES  per-core write request; level, held until ack
req_data  input  NUM_CORES*DATA_WIDTH  per-core write data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]; stable while req[i]=1
stall  input  1  R register busy; no grant issued while 1
ack  output  NUM_CORES  one-hot, one-cycle pulse: request i accepted
wr_en  output  1  write strobe to R register
wr_data  output  DATA_WIDTH  data to R register
grant_id  output  ID_WIDTH  index of the core granted in the current wr_en cycle
busy  output  1  1 when any unmasked req is pending and not being granted this cycle

Behaviour:
- Reset (rst=1, asynchronous): ack=0, wr_en=0, wr_data=0, grant_id=0, busy=0, rr_ptr=0.
  - Takes effect immediately, mid-operation included.
  - A grant in flight is dropped. The requester keeps req high and is re-arbitrated after reset.
- All outputs are registered.
- Arbitration happens at each rising edge with rst=0.
  - eligible[i] = req[i] & ~ack[i]. A requester acked in the current cycle is masked, because its req has not yet dropped.
  - If stall=1 or no eligible bit is set, the edge loads ack=0 and wr_en=0. wr_data and grant_id hold their values.
  - Otherwise the winner w is the first eligible index searching rr_ptr, rr_ptr+1, …, wrapping modulo NUM_CORES. The edge loads:
    - ack = one-hot(w), wr_en=1, wr_data = req_data slice w, grant_id = w
    - rr_ptr = (w+1) mod NUM_CORES
- Latency: req seen at edge k gives wr_en/ack high during cycle k+1. The R register captures wr_data at edge k+2.
- Requester rule: drop req, or present new data with req still high, at the edge ending its ack cycle.
  - The mask guarantees at most one write per request.
  - A back-to-back request from the same core is granted no earlier than 2 cycles after the previous ack.
- Fairness: with all NUM_CORES requesting continuously, each core receives exactly one grant in every NUM_CORES grants.
- stall:
  - Sampled at the edge.
  - stall=1 at edge k means no grant in cycle k+1.
  - A grant already presented in cycle k (wr_en=1) is not revoked.
  - rr_ptr is unchanged while stalled.
- busy: registered. Set at an edge where eligible≠0 and (stall=1 or popcount(eligible)>1). Cleared otherwise.
- Simultaneous req from all cores after reset: order 0,1,2,3,0,…
- Wrap-around: winner NUM_CORES-1 sets rr_ptr=0.
- req dropped before ack: permitted (withdrawal), no write occurs. If the drop coincides with the arbitrating edge, the old value sampled at that edge decides.
- wr_en and ack are never high without each other. popcount(ack) ≤ 1.

Test Plan:
- Reset mid-grant: req[2]=1, data 0x1234; assert rst during the wr_en cycle -> wr_en, ack, wr_data, grant_id go to 0 immediately. After rst release, req[2] is granted 1 cycle later with wr_data=0x1234.
- Single requester: req[1]=1, data 0xBEEF at edge k -> cycle k+1: wr_en=1, ack=0010, grant_id=1, wr_data=0xBEEF. Requester holds req through ack -> no second write in cycle k+2.
- Round-robin: req=1111, data slice i = 0x1000+i, each core drops and re-raises req after ack -> grant_id sequence 0,1,2,3,0,1,… with wr_data matching the slice.
- Stall: req=0101, stall=1 for 3 edges -> wr_en=0, busy=1. Release stall -> grant core 0 then core 2, rr_ptr continuing from its pre-stall value.
- Wrap: rr_ptr=3 with req=1001 -> core 3 granted first, then core 0.
- Withdrawal: req[3] raised and dropped before arbitration, with stall=1 -> no ack[3], no write, busy cleared.

Source files
------------

// File: rtl/regr_write_arbiter.sv
// Round-robin arbiter for the single write port of the 16-bit R register.
// One write per cycle; ack, strobe, data and grant index all come from registers.
module regr_write_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CORES-1:0]            req,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] req_data,
  input  logic                            stall,
  output logic [NUM_CORES-1:0]            ack,
  output logic                            wr_en,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [ID_WIDTH-1:0]             grant_id,
  output logic                            busy
);

  logic [NUM_CORES-1:0]  r_ack;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic                  r_busy;
  logic [ID_WIDTH-1:0]   r_ptr;

  logic [NUM_CORES-1:0]  w_eligible;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_winner;
  logic [ID_WIDTH-1:0]   w_ptr_nxt;
  logic                  w_multi;
  logic [DATA_WIDTH-1:0] w_win_data;

  // A core acked this cycle still has req high until the edge ending its ack.
  assign w_eligible = req & ~r_ack;
  assign w_multi    = (w_eligible & (w_eligible - NUM_CORES'(1))) != '0;

  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!w_found && w_eligible[idx]) begin
        w_found  = 1'b1;
        w_winner = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    w_ptr_nxt = '0;
    if (int'(w_winner) != NUM_CORES - 1) w_ptr_nxt = w_winner + ID_WIDTH'(1);
  end

  assign w_win_data = req_data[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_grant_id <= '0;
      r_busy     <= 1'b0;
      r_ptr      <= '0;
    end else begin
      r_busy <= (|w_eligible) & (stall | w_multi);
      if (stall || !w_found) begin
        r_ack   <= '0;
        r_wr_en <= 1'b0;
      end else begin
        r_ack      <= NUM_CORES'(1) << w_winner;
        r_wr_en    <= 1'b1;
        r_wr_data  <= w_win_data;
        r_grant_id <= w_winner;
        r_ptr      <= w_ptr_nxt;
      end
    end
  end

  assign ack      = r_ack;
  assign wr_en    = r_wr_en;
  assign wr_data  = r_wr_data;
  assign grant_id = r_grant_id;
  assign busy     = r_busy;

endmodule

// File: tb/tb_regr_write_arbiter.sv
// Bench for regr_write_arbiter: directed scenarios plus random requesters,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_regr_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            stall;
  logic [N-1:0]    ack;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [IW-1:0]   grant_id;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int           m_ptr;
  logic [N-1:0] m_ack;
  logic         m_wr_en;
  logic [DW-1:0] m_wr_data;
  int           m_gid;
  logic         m_busy;

  regr_write_arbiter #(.NUM_CORES(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .stall(stall),
    .ack(ack), .wr_en(wr_en), .wr_data(wr_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ptr = 0; m_ack = '0; m_wr_en = 1'b0; m_wr_data = '0; m_gid = 0; m_busy = 1'b0;
  endtask

  // Predict from inputs held before the edge, advance one clock, compare.
  task automatic step();
    int w, cnt, idx;
    bit el [N];
    w = -1; cnt = 0;
    for (int i = 0; i < N; i++) begin
      el[i] = (req[i] === 1'b1) && !m_ack[i];
      if (el[i]) cnt++;
    end
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (w < 0 && el[idx]) w = idx;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_reset();
    end else begin
      m_busy = (cnt > 0) && (stall || cnt > 1);
      if (stall || w < 0) begin
        m_ack = '0; m_wr_en = 1'b0;
      end else begin
        m_ack     = N'(1) << w;
        m_wr_en   = 1'b1;
        m_wr_data = req_data[w*DW +: DW];
        m_gid     = w;
        m_ptr     = (w + 1) % N;
      end
    end
    chk_eq("ack", 32'(ack), 32'(m_ack));
    chk_eq("wr_en", 32'(wr_en), 32'(m_wr_en));
    chk_eq("wr_data", 32'(wr_data), 32'(m_wr_data));
    chk_eq("grant_id", 32'(grant_id), 32'(m_gid));
    chk_eq("busy", 32'(busy), 32'(m_busy));
  endtask

  initial begin
    int seq_k;
    rst = 1'b1; req = '0; req_data = '0; stall = 1'b0;
    m_reset();
    #2;
    chk_eq("rst_wr_en", 32'(wr_en), 32'd0);
    chk_eq("rst_ack", 32'(ack), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // reset in the middle of a grant
    req = 4'b0100; req_data[2*DW +: DW] = 16'h1234;
    step();
    chk_eq("mid_pre_wr_en", 32'(wr_en), 32'd1);
    #2; rst = 1'b1; #1;
    chk_eq("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk_eq("mid_rst_ack", 32'(ack), 32'd0);
    chk_eq("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk_eq("mid_rst_gid", 32'(grant_id), 32'd0);
    m_reset();
    step();
    rst = 1'b0;
    step();
    chk_eq("post_rst_ack", 32'(ack), 32'b0100);
    chk_eq("post_rst_data", 32'(wr_data), 32'h1234);
    req = '0;
    step(); step();

    // single requester holding through its ack
    req = 4'b0010; req_data[1*DW +: DW] = 16'hBEEF;
    step();
    chk_eq("single_ack", 32'(ack), 32'b0010);
    chk_eq("single_gid", 32'(grant_id), 32'd1);
    chk_eq("single_data", 32'(wr_data), 32'hBEEF);
    step();
    chk_eq("single_no_rewrite", 32'(wr_en), 32'd0);
    req = '0;
    step();

    // round-robin from reset, acked core drops then re-raises
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 16'(16'h1000 + i);
    req = '1;
    seq_k = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      req = '1;
      if (wr_en === 1'b1) begin
        chk_eq("rr_gid", 32'(grant_id), 32'(seq_k % N));
        chk_eq("rr_data", 32'(wr_data), 32'(16'h1000 + (seq_k % N)));
        seq_k++;
        req[grant_id] = 1'b0;
      end
    end
    chk_eq("rr_count", 32'(seq_k >= 6), 32'd1);
    req = '0; step(); step();

    // stall with two requesters
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b0101; stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      chk_eq("stall_wr_en", 32'(wr_en), 32'd0);
      chk_eq("stall_busy", 32'(busy), 32'd1);
    end
    stall = 1'b0;
    step();
    chk_eq("stall_rel_gid0", 32'(grant_id), 32'd0);
    req = 4'b0100;
    step();
    chk_eq("stall_rel_gid2", 32'(grant_id), 32'd2);
    req = '0; step();

    // wrap: leave rr_ptr at 3, then cores 3 and 0
    req = 4'b0100; step();
    req = 4'b1001; req_data[3*DW +: DW] = 16'hC003; req_data[0 +: DW] = 16'hC000;
    step();
    chk_eq("wrap_first", 32'(grant_id), 32'd3);
    req = 4'b0001;
    step();
    chk_eq("wrap_second", 32'(grant_id), 32'd0);
    req = '0; step();

    // withdrawal while stalled
    stall = 1'b1; req = 4'b1000;
    step();
    req = 4'b0000;
    step();
    chk_eq("wd_busy", 32'(busy), 32'd0);
    stall = 1'b0;
    step();
    chk_eq("wd_no_ack", 32'(ack), 32'd0);

    // random traffic obeying the requester rules
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      rst   = ($urandom_range(0, 249) == 0);
      step();
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else req_data[i*DW +: DW] = 16'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            req_data[i*DW +: DW] = 16'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    rst = 1'b0; stall = 1'b0; req = '0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
